// File: rtl/montgomery_product_if.sv
// rtl/montgomery_product_if.sv - operand/result bundle for the Montgomery multiplier
interface montgomery_product_if;
   logic         start;
   logic [255:0] a;
   logic [255:0] b;
   logic [255:0] N;
   logic [255:0] out;
   logic         out_ready;
   logic         busy;

   // Requester side: drives operands and start, observes result
   modport master (
      output start, a, b, N,
      input  out, out_ready, busy
   );

   // Multiplier side
   modport slave (
      input  start, a, b, N,
      output out, out_ready, busy
   );
endinterface

// File: rtl/montgomery_product.sv
// rtl/montgomery_product.sv - bit-serial 256-bit Montgomery product a*b*2^-256 mod N
module montgomery_product (
   input  logic                 clk,
   input  logic                 beg,
   montgomery_product_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOOP  = 2'd1,
      ST_FINAL = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [255:0]  a_q, a_d;
   logic [255:0]  b_q, b_d;
   logic [255:0]  n_q, n_d;
   logic [255:0]  out_q, out_d;
   logic [257:0]  m_q, m_d;
   logic [8:0]    i_q, i_d;
   logic          out_ready_q, out_ready_d;
   logic          busy_q, busy_d;

   // One extra bit above the 258-bit accumulator so nothing is lost before the halving
   logic [258:0]  t_add;
   logic [258:0]  t_red;
   logic [255:0]  m_sub;
   logic          m_ge_n;
   logic          unused_t0;

   // Iteration datapath: add b when the current multiplier bit is set, make even with N, halve
   always_comb begin
      t_add     = {1'b0, m_q} + (a_q[i_q[7:0]] ? {3'b000, b_q} : 259'd0);
      t_red     = t_add[0] ? (t_add + {3'b000, n_q}) : t_add;
      m_ge_n    = (m_q >= {2'b00, n_q});
      // m < 2N, so m - N < 2^256 whenever the subtraction is taken
      m_sub     = m_q[255:0] - n_q;
      unused_t0 = t_red[0];
   end

   // Next-state and register-update logic
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      n_d         = n_q;
      out_d       = out_q;
      m_d         = m_q;
      i_d         = i_q;
      out_ready_d = 1'b0;
      busy_d      = busy_q;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               a_d     = bus.a;
               b_d     = bus.b;
               n_d     = bus.N;
               m_d     = '0;
               i_d     = '0;
               busy_d  = 1'b1;
               state_d = ST_LOOP;
            end
         end
         ST_LOOP: begin
            m_d = t_red[258:1];
            i_d = i_q + 9'd1;
            if (i_q == 9'd255) begin
               state_d = ST_FINAL;
            end
         end
         ST_FINAL: begin
            out_d       = m_ge_n ? m_sub : m_q[255:0];
            out_ready_d = 1'b1;
            busy_d      = 1'b0;
            state_d     = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State register with asynchronous reset that aborts any running operation
   always_ff @(posedge clk or negedge beg) begin
      if (!beg) begin
         state_q     <= ST_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         n_q         <= '0;
         out_q       <= '0;
         m_q         <= '0;
         i_q         <= '0;
         out_ready_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         n_q         <= n_d;
         out_q       <= out_d;
         m_q         <= m_d;
         i_q         <= i_d;
         out_ready_q <= out_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.out       = out_q;
   assign bus.out_ready = out_ready_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_montgomery_product.sv
// tb/tb_montgomery_product.sv - self-checking bench for montgomery_product
module tb_montgomery_product;

   localparam logic [255:0] NMAX = {256{1'b1}};

   logic clk;
   logic beg;
   int   checks;
   int   errors;

   montgomery_product_if mp_if ();

   montgomery_product dut (
      .clk (clk),
      .beg (beg),
      .bus (mp_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Golden value: reduce a*b mod N, then multiply by 2^-1 mod N 256 times
   function automatic logic [255:0] golden(input logic [255:0] a, input logic [255:0] b,
                                           input logic [255:0] n);
      logic [511:0] p;
      logic [256:0] x;
      p = ({256'd0, a} * {256'd0, b}) % {256'd0, n};
      x = {1'b0, p[255:0]};
      for (int k = 0; k < 256; k++) begin
         if (x[0]) x = x + {1'b0, n};
         x = x >> 1;
      end
      return x[255:0];
   endfunction

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Timing-level model: a countdown from the accepted start to the result cycle
   int           mdl_cnt;
   logic [255:0] mdl_res;
   logic [255:0] mdl_out;
   logic         mdl_ready;
   logic         mdl_busy;

   // Reference behaviour of the outputs, cycle by cycle
   always @(posedge clk or negedge beg) begin
      if (!beg) begin
         mdl_cnt   <= 0;
         mdl_out   <= '0;
         mdl_ready <= 1'b0;
         mdl_busy  <= 1'b0;
      end else begin
         mdl_ready <= 1'b0;
         if (mdl_cnt == 0) begin
            if (mp_if.start) begin
               mdl_res  <= golden(mp_if.a, mp_if.b, mp_if.N);
               mdl_cnt  <= 257;
               mdl_busy <= 1'b1;
            end
         end else begin
            mdl_cnt <= mdl_cnt - 1;
            if (mdl_cnt == 1) begin
               mdl_out   <= mdl_res;
               mdl_ready <= 1'b1;
               mdl_busy  <= 1'b0;
            end
         end
      end
   end

   // Compare DUT outputs with the model away from the active edge
   always @(negedge clk) begin
      checks++;
      if (mp_if.out !== mdl_out || mp_if.out_ready !== mdl_ready || mp_if.busy !== mdl_busy) begin
         errors++;
         $display("FAIL cycle_cmp t=%0t actual out=%h rdy=%b busy=%b required out=%h rdy=%b busy=%b",
                  $time, mp_if.out, mp_if.out_ready, mp_if.busy, mdl_out, mdl_ready, mdl_busy);
      end
   end

   // Wait for out_ready, optionally poking start at two cycle offsets; lat counts edges after E0
   task automatic wait_ready(input int poke1, input int poke2, output int lat);
      lat = 0;
      while (!mp_if.out_ready && lat < 300) begin
         mp_if.start = (lat == poke1 || lat == poke2);
         @(negedge clk);
         lat++;
      end
      mp_if.start = 1'b0;
      if (!mp_if.out_ready) begin
         errors++;
         checks++;
         $display("FAIL timeout actual=no_out_ready required=out_ready");
      end
   endtask

   // Issue one operation, scramble inputs after the start cycle, check latency and result
   task automatic run_op(input string name, input logic [255:0] a, input logic [255:0] b,
                         input logic [255:0] n, input logic [255:0] exp);
      int lat;
      @(negedge clk);
      mp_if.a = a; mp_if.b = b; mp_if.N = n; mp_if.start = 1'b1;
      @(negedge clk);
      mp_if.start = 1'b0;
      mp_if.a = ~a; mp_if.b = ~b; mp_if.N = rand256();
      wait_ready(-1, -1, lat);
      chk({name, "_lat"}, 256'(lat), 256'd257);
      chk({name, "_out"}, mp_if.out, exp);
   endtask

   initial begin
      logic [255:0] n, a, b;
      logic [511:0] wide;
      int           lat;
      checks = 0;
      errors = 0;
      mp_if.start = 1'b0;
      mp_if.a = '0; mp_if.b = '0; mp_if.N = '0;
      beg = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_out", mp_if.out, '0);
      chk("reset_rdy", 256'(mp_if.out_ready), '0);
      chk("reset_busy", 256'(mp_if.busy), '0);
      beg = 1'b1;

      // Pin the golden model with hand-computed values
      chk("model_5x7", golden(256'd5, 256'd7, NMAX), 256'd35);
      chk("model_max", golden(NMAX - 1, NMAX - 1, NMAX), 256'd1);
      chk("model_n13", golden(256'd3, 256'd3, 256'd13), 256'd3);

      run_op("mul_5x7", 256'd5, 256'd7, NMAX, 256'd35);
      run_op("mul_max", NMAX - 1, NMAX - 1, NMAX, 256'd1);
      run_op("mul_zero", 256'd0, NMAX - 1, NMAX, 256'd0);
      // 2^256 mod 13 = 3 (2^12 = 1 mod 13, 256 = 21*12 + 4)
      run_op("mul_n13", 256'd3, 256'd3, 256'd13, 256'd3);

      // Montgomery-domain operand 3*2^256 mod N times 1 returns to 3
      n = rand256() | {1'b1, 254'd0, 1'b1};
      wide = {256'd3, 256'd0} % {256'd0, n};
      run_op("chain_m3", wide[255:0], 256'd1, n, 256'd3);

      for (int k = 0; k < 200; k++) begin
         n = rand256() | 256'd1;
         if (n < 256'd3) n = 256'd3;
         a = rand256() % n;
         b = rand256() % n;
         run_op($sformatf("rand%0d", k), a, b, n, golden(a, b, n));
      end

      // start pokes during LOOP are ignored; back-to-back start in the out_ready cycle
      @(negedge clk);
      mp_if.a = 256'd11; mp_if.b = 256'd13; mp_if.N = NMAX; mp_if.start = 1'b1;
      @(negedge clk);
      mp_if.start = 1'b0;
      mp_if.a = 256'd99; mp_if.b = 256'd98;
      wait_ready(10, 100, lat);
      chk("poke_lat", 256'(lat), 256'd257);
      chk("poke_out", mp_if.out, 256'd143);
      mp_if.a = 256'd4; mp_if.b = 256'd9; mp_if.N = NMAX; mp_if.start = 1'b1;
      @(negedge clk);
      mp_if.start = 1'b0;
      wait_ready(-1, -1, lat);
      chk("b2b_lat", 256'(lat), 256'd257);
      chk("b2b_out", mp_if.out, 256'd36);

      // Asynchronous reset at cycle 120 of an operation
      @(negedge clk);
      mp_if.a = 256'd7; mp_if.b = 256'd8; mp_if.N = NMAX; mp_if.start = 1'b1;
      @(negedge clk);
      mp_if.start = 1'b0;
      repeat (120) @(negedge clk);
      #2 beg = 1'b0;
      #1;
      chk("rst_out", mp_if.out, '0);
      chk("rst_rdy", 256'(mp_if.out_ready), '0);
      chk("rst_busy", 256'(mp_if.busy), '0);
      repeat (3) @(negedge clk);
      beg = 1'b1;
      lat = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (mp_if.out_ready) lat++;
      end
      chk("rst_no_pulse", 256'(lat), '0);
      run_op("after_rst", 256'd2, 256'd3, NMAX, 256'd6);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
